// File: rtl/rpn_logic_pkg.sv
// Shared opcodes, FSM state encoding and per-opcode stack requirements
// for the RPN bitwise logic stage.
package rpn_logic_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SWAP = 4'd7;
  localparam logic [3:0] OP_DUP  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_t;

  function automatic int unsigned op_min_depth(input logic [3:0] op);
    case (op)
      OP_POP, OP_NOT, OP_DUP:           op_min_depth = 1;
      OP_AND, OP_OR, OP_XOR, OP_SWAP:   op_min_depth = 2;
      default:                          op_min_depth = 0;
    endcase
  endfunction

  // Opcodes that add an entry and therefore need a free slot.
  function automatic logic op_grows(input logic [3:0] op);
    op_grows = (op == OP_PUSH) || (op == OP_DUP);
  endfunction

  function automatic logic op_defined(input logic [3:0] op);
    op_defined = (op <= OP_CLR);
  endfunction

endpackage

// File: rtl/rpn_bitwise_core.sv
// Combinational bitwise unit: AND/OR/XOR of a and b, or NOT of a.
module rpn_bitwise_core
  import rpn_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_logic_stack.sv
// WIDTH-bit, DEPTH-entry operand stack applying bitwise ops in RPN order,
// with a sticky error state that discards commands until CLR.
//
// state  | meaning
// -------+--------------------------------------------------------------
// RUN    | commands execute; a fault leaves the stack as-is and enters ERR
// ERR    | err=1; all commands except CLR are accepted and discarded
module rpn_logic_stack
  import rpn_logic_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             res_valid,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             zero,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DW-1:0]    r_depth;
  logic [DW-1:0]    w_depth_nxt;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_stack     [DEPTH];
  logic [WIDTH-1:0] w_stack_nxt [DEPTH];

  logic             w_accept;
  logic             w_full;
  logic             w_legal;
  logic [AW-1:0]    w_t_idx;
  logic [AW-1:0]    w_s_idx;
  logic [AW-1:0]    w_p_idx;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_core_y;

  assign cmd_ready = !reset;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_full    = (r_depth == DW'(DEPTH));

  // Entry i lives at r_stack[i]; T sits at depth-1, S at depth-2.
  assign w_t_idx = AW'(r_depth - DW'(1));
  assign w_s_idx = AW'(r_depth - DW'(2));
  assign w_p_idx = AW'(r_depth);
  assign w_t     = r_stack[w_t_idx];
  assign w_s     = r_stack[w_s_idx];

  assign w_legal = op_defined(cmd_op)
                && (32'(r_depth) >= op_min_depth(cmd_op))
                && !(op_grows(cmd_op) && w_full);

  // T on the a side so NOT inverts the top; AND/OR/XOR are commutative.
  rpn_bitwise_core #(.WIDTH(WIDTH)) u_core (
    .a  (w_t),
    .b  (w_s),
    .op (cmd_op),
    .y  (w_core_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_depth     <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_depth     <= w_depth_nxt;
      r_res_valid <= w_accept && (cmd_op != OP_NOP);
    end
  end

  // Contents above depth are don't-care, so the array needs no reset.
  always_ff @(posedge clk) begin
    r_stack <= w_stack_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_stack_nxt = r_stack;
    if (w_accept) begin
      if (cmd_op == OP_CLR) begin
        w_state_nxt = ST_RUN;
        w_depth_nxt = '0;
      end else if (r_state == ST_RUN) begin
        if (!w_legal) begin
          w_state_nxt = ST_ERR;
        end else begin
          case (cmd_op)
            OP_PUSH: begin
              w_stack_nxt[w_p_idx] = cmd_data;
              w_depth_nxt          = r_depth + DW'(1);
            end
            OP_DUP: begin
              w_stack_nxt[w_p_idx] = w_t;
              w_depth_nxt          = r_depth + DW'(1);
            end
            OP_POP: begin
              w_depth_nxt = r_depth - DW'(1);
            end
            OP_AND, OP_OR, OP_XOR: begin
              w_stack_nxt[w_s_idx] = w_core_y;
              w_depth_nxt          = r_depth - DW'(1);
            end
            OP_NOT: begin
              w_stack_nxt[w_t_idx] = w_core_y;
            end
            OP_SWAP: begin
              w_stack_nxt[w_t_idx] = w_s;
              w_stack_nxt[w_s_idx] = w_t;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign res_valid = r_res_valid;
  assign depth     = r_depth;
  assign empty     = (r_depth == '0);
  assign full      = w_full;
  assign top       = empty ? '0 : w_t;
  assign zero      = !empty && (top == '0);
  assign err       = (r_state == ST_ERR);

endmodule

// File: tb/tb_rpn_logic_stack.sv
// Directed checks of rpn_logic_stack at 8x4 and 16x8 configurations.
module tb_rpn_logic_stack;
  import rpn_logic_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [7:0]  cmd_data = '0;
  logic        cmd_ready, res_valid, empty, full, zero, err;
  logic [7:0]  top;
  logic [2:0]  depth;

  logic        cmd_valid_w = 1'b0;
  logic [3:0]  cmd_op_w = '0;
  logic [15:0] cmd_data_w = '0;
  logic        cmd_ready_w, res_valid_w, empty_w, full_w, zero_w, err_w;
  logic [15:0] top_w;
  logic [3:0]  depth_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpn_logic_stack #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .res_valid(res_valid), .top(top),
    .depth(depth), .empty(empty), .full(full), .zero(zero), .err(err)
  );

  rpn_logic_stack #(.WIDTH(16), .DEPTH(8)) dut_w (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid_w), .cmd_ready(cmd_ready_w),
    .cmd_op(cmd_op_w), .cmd_data(cmd_data_w), .res_valid(res_valid_w), .top(top_w),
    .depth(depth_w), .empty(empty_w), .full(full_w), .zero(zero_w), .err(err_w)
  );

  task automatic issue(input logic [3:0] op, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue_w(input logic [3:0] op, input logic [15:0] d);
    @(negedge clk);
    cmd_valid_w = 1'b1; cmd_op_w = op; cmd_data_w = d;
    @(posedge clk); #1;
    cmd_valid_w = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b0) begin $display("FAIL reset_ready got %b want 0", cmd_ready); errors++; end
    checks++; if (depth !== 3'd0) begin $display("FAIL reset_depth got %0d want 0", depth); errors++; end
    checks++; if (top !== 8'h00) begin $display("FAIL reset_top got %h want 00", top); errors++; end
    checks++; if ({empty, full, zero, err, res_valid} !== 5'b10000) begin
      $display("FAIL reset_flags got %b want 10000", {empty, full, zero, err, res_valid}); errors++; end
    checks++; if ({depth_w, empty_w, err_w} !== 6'b0000_1_0) begin
      $display("FAIL reset_wide got %b want 000010", {depth_w, empty_w, err_w}); errors++; end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin $display("FAIL ready_after_reset got %b want 1", cmd_ready); errors++; end
  endtask

  task automatic test_and();
    do_reset();
    issue(OP_PUSH, 8'h3C);
    checks++; if ({res_valid, depth, top} !== {1'b1, 3'd1, 8'h3C}) begin
      $display("FAIL push1 got rv=%b d=%0d t=%h want 1 1 3c", res_valid, depth, top); errors++; end
    issue(OP_PUSH, 8'h0F);
    checks++; if ({res_valid, depth, top} !== {1'b1, 3'd2, 8'h0F}) begin
      $display("FAIL push2 got rv=%b d=%0d t=%h want 1 2 0f", res_valid, depth, top); errors++; end
    issue(OP_AND, 8'hFF);
    checks++; if ({res_valid, depth, top} !== {1'b1, 3'd1, 8'h0C}) begin
      $display("FAIL and got rv=%b d=%0d t=%h want 1 1 0c", res_valid, depth, top); errors++; end
    @(posedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin $display("FAIL and_rv_drop got %b want 0", res_valid); errors++; end
  endtask

  task automatic test_xor_not_err();
    do_reset();
    issue(OP_PUSH, 8'hAA);
    issue(OP_PUSH, 8'h55);
    issue(OP_XOR, 8'h00);
    checks++; if ({depth, top} !== {3'd1, 8'hFF}) begin
      $display("FAIL xor got d=%0d t=%h want 1 ff", depth, top); errors++; end
    issue(OP_NOT, 8'h00);
    checks++; if ({depth, top, zero, err} !== {3'd1, 8'h00, 1'b1, 1'b0}) begin
      $display("FAIL not got d=%0d t=%h z=%b e=%b want 1 00 1 0", depth, top, zero, err); errors++; end
    issue(OP_OR, 8'h00);
    checks++; if ({err, depth, top, res_valid} !== {1'b1, 3'd1, 8'h00, 1'b1}) begin
      $display("FAIL or_depth1 got e=%b d=%0d t=%h rv=%b want 1 1 00 1", err, depth, top, res_valid); errors++; end
    issue(OP_PUSH, 8'h11);
    checks++; if ({err, depth, top, res_valid} !== {1'b1, 3'd1, 8'h00, 1'b1}) begin
      $display("FAIL err_discard got e=%b d=%0d t=%h rv=%b want 1 1 00 1", err, depth, top, res_valid); errors++; end
    issue(OP_CLR, 8'h00);
    checks++; if ({err, depth, empty, top} !== {1'b0, 3'd0, 1'b1, 8'h00}) begin
      $display("FAIL clr_from_err got e=%b d=%0d em=%b t=%h want 0 0 1 00", err, depth, empty, top); errors++; end
    issue(OP_PUSH, 8'h11);
    checks++; if ({top, depth, err} !== {8'h11, 3'd1, 1'b0}) begin
      $display("FAIL push_after_clr got t=%h d=%0d e=%b want 11 1 0", top, depth, err); errors++; end
  endtask

  task automatic test_full();
    do_reset();
    issue(OP_PUSH, 8'h01);
    issue(OP_PUSH, 8'h02);
    issue(OP_PUSH, 8'h03);
    checks++; if (full !== 1'b0) begin $display("FAIL full_at3 got %b want 0", full); errors++; end
    issue(OP_PUSH, 8'h04);
    checks++; if ({full, depth, top} !== {1'b1, 3'd4, 8'h04}) begin
      $display("FAIL full_at4 got f=%b d=%0d t=%h want 1 4 04", full, depth, top); errors++; end
    issue(OP_DUP, 8'h00);
    checks++; if ({err, depth, top} !== {1'b1, 3'd4, 8'h04}) begin
      $display("FAIL dup_full got e=%b d=%0d t=%h want 1 4 04", err, depth, top); errors++; end
    issue(OP_CLR, 8'h00);
    checks++; if ({err, depth, empty, full} !== {1'b0, 3'd0, 1'b1, 1'b0}) begin
      $display("FAIL clr_full got e=%b d=%0d em=%b f=%b want 0 0 1 0", err, depth, empty, full); errors++; end
    for (int i = 1; i <= 4; i++) issue(OP_PUSH, 8'(i * 16));
    issue(OP_PUSH, 8'h77);
    checks++; if ({err, depth, top} !== {1'b1, 3'd4, 8'h40}) begin
      $display("FAIL push_full got e=%b d=%0d t=%h want 1 4 40", err, depth, top); errors++; end
    issue(OP_CLR, 8'h00);
    issue(OP_POP, 8'h00);
    checks++; if ({err, depth, empty} !== {1'b1, 3'd0, 1'b1}) begin
      $display("FAIL pop_empty got e=%b d=%0d em=%b want 1 0 1", err, depth, empty); errors++; end
    issue(OP_CLR, 8'h00);
    issue(OP_PUSH, 8'h5A);
    issue(4'd12, 8'h00);
    checks++; if ({err, depth, top} !== {1'b1, 3'd1, 8'h5A}) begin
      $display("FAIL illegal_op got e=%b d=%0d t=%h want 1 1 5a", err, depth, top); errors++; end
  endtask

  task automatic test_swap_pop_reset();
    do_reset();
    issue(OP_PUSH, 8'h12);
    issue(OP_PUSH, 8'h34);
    issue(OP_SWAP, 8'h00);
    checks++; if ({top, depth} !== {8'h12, 3'd2}) begin
      $display("FAIL swap got t=%h d=%0d want 12 2", top, depth); errors++; end
    issue(OP_DUP, 8'h00);
    checks++; if ({top, depth} !== {8'h12, 3'd3}) begin
      $display("FAIL dup got t=%h d=%0d want 12 3", top, depth); errors++; end
    issue(OP_POP, 8'h00);
    issue(OP_POP, 8'h00);
    checks++; if ({top, depth, err} !== {8'h34, 3'd1, 1'b0}) begin
      $display("FAIL pop got t=%h d=%0d e=%b want 34 1 0", top, depth, err); errors++; end
    issue(OP_NOP, 8'h00);
    checks++; if ({res_valid, top, depth} !== {1'b0, 8'h34, 3'd1}) begin
      $display("FAIL nop got rv=%b t=%h d=%0d want 0 34 1", res_valid, top, depth); errors++; end
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = OP_PUSH; cmd_data = 8'hFF;
    @(posedge clk); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    checks++; if ({depth, top, err, res_valid} !== {3'd0, 8'h00, 1'b0, 1'b0}) begin
      $display("FAIL reset_vs_push got d=%0d t=%h e=%b rv=%b want 0 00 0 0", depth, top, err, res_valid); errors++; end
  endtask

  task automatic test_wide_idle();
    issue_w(OP_PUSH, 16'hF0F0);
    issue_w(OP_PUSH, 16'h0FF0);
    issue_w(OP_OR, 16'h0000);
    checks++; if ({top_w, depth_w, res_valid_w} !== {16'hFFF0, 4'd1, 1'b1}) begin
      $display("FAIL wide_or got t=%h d=%0d rv=%b want fff0 1 1", top_w, depth_w, res_valid_w); errors++; end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({top_w, depth_w, res_valid_w, err_w} !== {16'hFFF0, 4'd1, 1'b0, 1'b0}) begin
        $display("FAIL wide_idle%0d got t=%h d=%0d rv=%b e=%b want fff0 1 0 0", i, top_w, depth_w, res_valid_w, err_w);
        errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_xor_not_err();
    test_full();
    test_swap_pop_reset();
    test_wide_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
